// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM command-port arbiter.
package sdram_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // Requester port indices
  localparam logic [1:0] PORT_VIDEO = 2'd0;
  localparam logic [1:0] PORT_CPU   = 2'd1;
  localparam logic [1:0] PORT_AUX   = 2'd2;
  localparam int         NUM_PORTS  = 3;

  // One-hot ack vector for a port index
  function automatic logic [2:0] port_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester-side and controller-side bus of the SDRAM command-port arbiter.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int MASK_W = DATA_W / 8
);
  // requester side
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [3*MASK_W-1:0] wmask;
  logic [2:0]          ack;
  logic [DATA_W-1:0]   rdata;
  // controller side
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [MASK_W-1:0]   cmd_wmask;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  // status
  logic                busy;
  logic                err_stray;

  // arbiter view
  modport slave (
    input  req, we, addr, wdata, wmask, cmd_ready, rd_valid, rd_data,
    output ack, rdata, cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wmask,
           busy, err_stray
  );

  // requesters + controller view
  modport master (
    output req, we, addr, wdata, wmask, cmd_ready, rd_valid, rd_data,
    input  ack, rdata, cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wmask,
           busy, err_stray
  );
endinterface

// File: rtl/sdram_arb_grant.sv
// Grant selection: video port has fixed priority bounded by a run cap,
// CPU and AUX ports share the remaining slots round-robin.
module sdram_arb_grant
  import sdram_arb_pkg::*;
#(
  parameter int MAX_VIDEO_RUN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_req,
  input  logic       i_take,        // arbiter is idle and will latch the winner
  output logic       o_grant_valid,
  output logic [1:0] o_winner
);

  localparam int               RUN_W   = $clog2(MAX_VIDEO_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VIDEO_RUN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [RUN_W-1:0] r_run_cnt;
  logic [1:0]       r_rr_next;
  logic             w_others;
  logic             w_video_win;

  assign w_others      = |i_req[2:1];
  // Video loses its priority only once it has used up its run while others wait
  assign w_video_win   = i_req[0] && !((r_run_cnt == RUN_MAX) && w_others);
  assign o_grant_valid = |i_req;

  // Winner: video first, else rr_next if requesting, else the other shared port
  always_comb begin
    o_winner = PORT_VIDEO;
    if (!w_video_win) begin
      if (r_rr_next == PORT_CPU) begin
        o_winner = i_req[1] ? PORT_CPU : PORT_AUX;
      end else begin
        o_winner = i_req[2] ? PORT_AUX : PORT_CPU;
      end
    end
  end

  // Video run counter and round-robin pointer advance only on an actual grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cnt <= '0;
      r_rr_next <= PORT_CPU;
    end else if (i_take && o_grant_valid) begin
      if (o_winner == PORT_VIDEO) begin
        if (!w_others) begin
          r_run_cnt <= '0;
        end else if (r_run_cnt != RUN_MAX) begin
          r_run_cnt <= r_run_cnt + RUN_ONE;
        end
      end else begin
        r_run_cnt <= '0;
        r_rr_next <= (o_winner == PORT_CPU) ? PORT_AUX : PORT_CPU;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port among video, CPU and AUX
// requesters, with a single transaction outstanding at a time.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W        = 24,
  parameter int DATA_W        = 32,
  parameter int MASK_W        = DATA_W / 8,
  parameter int MAX_VIDEO_RUN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sdram_port_arbiter_if.slave  bus
);

  arb_state_t        r_state;
  logic [1:0]        r_gnt_idx;
  logic [2:0]        r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_cmd_valid;
  logic              r_cmd_we;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;
  logic [MASK_W-1:0] r_cmd_wmask;
  logic              r_err_stray;

  logic              w_take;
  logic              w_grant_valid;
  logic [1:0]        w_winner;
  logic [ADDR_W-1:0] w_addr  [NUM_PORTS];
  logic [DATA_W-1:0] w_wdata [NUM_PORTS];
  logic [MASK_W-1:0] w_wmask [NUM_PORTS];

  // Split the flat per-port buses into indexable arrays
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign w_addr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata[gi] = bus.wdata[gi*DATA_W +: DATA_W];
    assign w_wmask[gi] = bus.wmask[gi*MASK_W +: MASK_W];
  end

  assign w_take = (r_state == IDLE);

  sdram_arb_grant #(
    .MAX_VIDEO_RUN (MAX_VIDEO_RUN)
  ) u_grant (
    .clk           (clk),
    .rst           (rst),
    .i_req         (bus.req),
    .i_take        (w_take),
    .o_grant_valid (w_grant_valid),
    .o_winner      (w_winner)
  );

  // Transaction FSM: latch winner fields, hand off to controller, wait for
  // read return, then pulse the winner's ack for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt_idx   <= PORT_VIDEO;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_wmask <= '0;
      r_err_stray <= 1'b0;
    end else begin
      // A read return with no read outstanding is a controller/protocol fault
      if (bus.rd_valid && (r_state != WAIT_RD)) begin
        r_err_stray <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_ack <= '0;
          if (w_grant_valid) begin
            r_gnt_idx   <= w_winner;
            r_cmd_we    <= bus.we[w_winner];
            r_cmd_addr  <= w_addr[w_winner];
            r_cmd_wdata <= w_wdata[w_winner];
            r_cmd_wmask <= w_wmask[w_winner];
            r_cmd_valid <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_cmd_valid && bus.cmd_ready) begin
            r_cmd_valid <= 1'b0;
            if (r_cmd_we) begin
              r_ack   <= port_onehot(r_gnt_idx);
              r_state <= DONE;
            end else begin
              r_state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (bus.rd_valid) begin
            r_rdata <= bus.rd_data;
            r_ack   <= port_onehot(r_gnt_idx);
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ack   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_ack   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.rdata     = r_rdata;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_we    = r_cmd_we;
  assign bus.cmd_addr  = r_cmd_addr;
  assign bus.cmd_wdata = r_cmd_wdata;
  assign bus.cmd_wmask = r_cmd_wmask;
  assign bus.busy      = (r_state != IDLE);
  assign bus.err_stray = r_err_stray;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single 100 MHz SDRAM controller command port among three requesters: port 0 = video framebuffer fetch, port 1 = CPU, port 2 = auxiliary DMA (OSD/USB buffers).
- Sits in the clk_sdram domain between the requesters' CDC stages and the SDRAM controller.
- Port 0 has fixed priority, with a starvation cap. Ports 1 and 2 alternate round-robin.
- One transaction is outstanding at a time.

Parameters:
- ADDR_W, 24, word address width.
- DATA_W, 32, data width.
- MASK_W, DATA_W/8, byte-enable width.
- MAX_VIDEO_RUN, 4, consecutive port-0 grants allowed while port 1 or port 2 is pending.

Ports:
- clk  in  1  clk_sdram; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req  in  3  per-port request level; bit n = port n.
- we  in  3  per-port write flag (1 = write).
- addr  in  3*ADDR_W  per-port address; port n at [n*ADDR_W +: ADDR_W].
- wdata  in  3*DATA_W  per-port write data.
- wmask  in  3*MASK_W  per-port byte enables, active-high.
- ack  out  3  one-cycle completion pulse per port.
- rdata  out  DATA_W  read data; valid in the cycle the ack bit is high.
- cmd_valid  out  1  command to the controller.
- cmd_ready  in  1  controller accepts the command.
- cmd_we, cmd_addr, cmd_wdata, cmd_wmask  out  1/ADDR_W/DATA_W/MASK_W  latched command fields.
- rd_valid  in  1  controller read-return strobe.
- rd_data  in  DATA_W  controller read data.
- busy  out  1  high whenever state is not IDLE.
- err_stray  out  1  sticky flag: rd_valid arrived outside WAIT_RD.

Behaviour:
- Reset values:
  - state = IDLE; ack = 0; cmd_valid = 0; cmd_* fields = 0; rdata = 0; busy = 0; err_stray = 0.
  - rr_next = port 1; run_cnt = 0.
- Reset mid-transaction abandons the transaction with no ack. The SDRAM controller is reset by the same rst.
- Requester contract:
  - Hold req and the port's fields stable until that port's ack.
  - Dropping req early is illegal. The arbiter still completes the transaction and pulses ack.
- IDLE:
  - Grant evaluation happens only here, only when any req bit is high.
  - Priority rule:
    - Port 0 wins if req[0] and NOT (run_cnt == MAX_VIDEO_RUN and req[2:1] != 0).
    - Otherwise, among ports 1 and 2, the winner is rr_next if it requests, else the other port.
  - On grant: latch we/addr/wdata/wmask of the winner into cmd_* and the winner index into gnt_idx; go to ISSUE.
- run_cnt update (at grant):
  - Port 0 granted while req[2:1] != 0: run_cnt + 1, saturating at MAX_VIDEO_RUN.
  - Port 0 granted while req[2:1] == 0: run_cnt = 0.
  - Port 1 or 2 granted: run_cnt = 0, and rr_next = the other of ports 1/2.
- ISSUE:
  - cmd_valid = 1. Fields are stable until acceptance (cmd_valid && cmd_ready).
  - On acceptance, cmd_valid drops the next cycle.
  - Write: go to DONE.
  - Read: go to WAIT_RD.
- WAIT_RD: on rd_valid, register rdata = rd_data and go to DONE. No timeout.
- DONE:
  - ack[gnt_idx] = 1 for exactly one cycle; rdata is held.
  - Next cycle: IDLE.
- Latency:
  - Write: req rises at cycle 0 with cmd_ready constantly 1 → cmd_valid in cycle 1 → ack in cycle 2 → next grant can occur in cycle 3.
  - Read: ack is high 1 cycle after rd_valid.
- Simultaneous events:
  - rd_valid in the same cycle as another port's new req: no conflict, since grants happen only in IDLE.
  - rd_valid outside WAIT_RD: ignored, and err_stray is set until rst.
- ack is never asserted to a port that is not gnt_idx. At most one ack bit is high in any cycle.

Decomposition:
- Package sdram_arb_pkg holds:
  - State encoding: IDLE, ISSUE, WAIT_RD, DONE.
  - Port index constants: PORT_VIDEO = 0, PORT_CPU = 1, PORT_AUX = 2.
- Sub-module sdram_arb_grant is the natural split. It owns the rr_next and run_cnt registers and computes the winner index and grant_valid from req. The top FSM owns field latching, the handshake and ack.

Test Plan:
- Single CPU write; req = 3'b010, cmd_ready = 1 → cmd_valid high 1 cycle with the port-1 fields, ack = 3'b010 in cycle 2, busy low in cycle 3.
- Port 2 read of addr 0x00_1234; controller returns rd_valid 5 cycles after accept with rd_data 0xC01DCAFE → rdata = 0xC01DCAFE coincident with ack = 3'b100.
- All three ports requesting continuously, MAX_VIDEO_RUN = 4 → grant order 0,0,0,0,1,0,0,0,0,2,… and run_cnt never exceeds 4.
- Ports 1 and 2 only, both held → strict alternation 1,2,1,2; cmd_ready held low 10 cycles in ISSUE → cmd fields stable throughout and no ack during the stall.
- rst asserted while in WAIT_RD → next cycle: state IDLE, no ack, cmd_valid = 0, rr_next = 1. A later rd_valid sets err_stray = 1.
- rd_valid pulsed in IDLE with no grant → err_stray = 1, which stays set until rst, and no ack is generated.
